// File: rtl/mw_defs_pkg.sv
// mw_defs: shared state encodings, status colours and power helpers for the microwave controller
package mw_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COOK  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } st_t;

    localparam logic [2:0] RGB_COOK = 3'b101;
    localparam logic [2:0] RGB_IDLE = 3'b110;
    localparam logic [2:0] RGB_DONE = 3'b011;

    localparam logic [3:0] MAX_POWER = 4'd10;

    // Out-of-range panel settings saturate to full power rather than wrapping.
    function automatic logic [3:0] clamp_power(input logic [3:0] p);
        return (p > MAX_POWER) ? MAX_POWER : p;
    endfunction

    // PAUSE shares the IDLE colour.
    function automatic logic [2:0] rgb_of(input st_t s);
        return (s == ST_COOK) ? RGB_COOK : (s == ST_DONE) ? RGB_DONE : RGB_IDLE;
    endfunction

endpackage

// File: rtl/mw_beeper.sv
// mw_beeper: end-of-cook beeper producing BEEP_COUNT on/off beeps timed in tick_100Hz strobes
module mw_beeper
    import mw_defs::*;
#(
    parameter int BEEP_HALF  = 50,
    parameter int BEEP_COUNT = 3
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic tick_100Hz,
    input  logic start,
    input  logic abort,
    output logic beeper,
    output logic done
);

    localparam int HW = $clog2(BEEP_HALF + 1);
    localparam int CW = $clog2(BEEP_COUNT + 1);

    logic          active;
    logic [HW-1:0] half_cnt;
    logic [CW-1:0] beep_cnt;
    logic          half_end;
    logic          last_beep;

    assign half_end  = half_cnt == HW'(BEEP_HALF - 1);
    assign last_beep = beep_cnt == CW'(BEEP_COUNT - 1);

    // done is combinational so the controller leaves DONE on the very tick that ends the last off-phase.
    assign done = active && tick_100Hz && half_end && !beeper && last_beep;

    // Beeper starts on the same edge the controller enters DONE; each tick advances the half-period counter.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            active   <= 1'b0;
            beeper   <= 1'b0;
            half_cnt <= '0;
            beep_cnt <= '0;
        end else if (abort) begin
            active   <= 1'b0;
            beeper   <= 1'b0;
            half_cnt <= '0;
            beep_cnt <= '0;
        end else if (start) begin
            active   <= 1'b1;
            beeper   <= 1'b1;
            half_cnt <= '0;
            beep_cnt <= '0;
        end else if (active && tick_100Hz) begin
            half_cnt <= half_end ? '0 : half_cnt + HW'(1);
            if (half_end) begin
                if (beeper) begin
                    beeper <= 1'b0;
                end else if (last_beep) begin
                    active <= 1'b0;
                end else begin
                    beep_cnt <= beep_cnt + CW'(1);
                    beeper   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/microwave_ctrl.sv
// microwave_ctrl: cook sequencing FSM with power latch, magnetron duty window and registered panel outputs
module microwave_ctrl
    import mw_defs::*;
#(
    parameter int TICKS_PER_SEC = 100,
    parameter int BEEP_HALF     = 50,
    parameter int BEEP_COUNT    = 3
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       tick_100Hz,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       door_open,
    input  logic       time_zero,
    input  logic [3:0] power_lvl,
    output logic       timer_run,
    output logic       timer_clear,
    output logic       magnetron_on,
    output logic       lamp_on,
    output logic       beeper,
    output logic [1:0] state,
    output logic [2:0] rgb
);

    localparam int DW = $clog2(TICKS_PER_SEC) + 1;

    st_t           st;
    st_t           nxt;
    logic          clr;
    logic [3:0]    pwr_q;
    logic [DW-1:0] duty_cnt;
    logic [DW-1:0] pwr_x10;
    logic          can_start;
    logic          bp_start;
    logic          bp_abort;
    logic          bp_done;

    assign state     = st;
    assign can_start = btn_start && !door_open && !time_zero;
    assign pwr_x10   = DW'(pwr_q) * DW'(10);
    assign bp_start  = (st == ST_COOK) && (nxt == ST_DONE);
    assign bp_abort  = (st == ST_DONE) && (btn_stop || door_open);

    // Next-state decode; stop is checked first everywhere so it beats a simultaneous start.
    always_comb begin
        nxt = st;
        clr = 1'b0;
        case (st)
            ST_IDLE:  if (btn_stop) clr = 1'b1;
                      else if (can_start) nxt = ST_COOK;
            ST_COOK:  if (door_open || btn_stop) nxt = ST_PAUSE;
                      else if (time_zero) nxt = ST_DONE;
            ST_PAUSE: if (btn_stop) begin
                          nxt = ST_IDLE;
                          clr = 1'b1;
                      end else if (can_start) nxt = ST_COOK;
            ST_DONE:  if (btn_stop || door_open || bp_done) nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    // State, power latch, duty window and all registered outputs.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            st           <= ST_IDLE;
            pwr_q        <= '0;
            duty_cnt     <= '0;
            timer_run    <= 1'b0;
            timer_clear  <= 1'b0;
            magnetron_on <= 1'b0;
            lamp_on      <= 1'b0;
            rgb          <= RGB_IDLE;
        end else begin
            st          <= nxt;
            timer_run   <= nxt == ST_COOK;
            timer_clear <= clr;
            lamp_on     <= (nxt == ST_COOK) || door_open;
            rgb         <= rgb_of(nxt);
            if (st == ST_IDLE && nxt == ST_COOK)
                pwr_q <= clamp_power(power_lvl);
            duty_cnt <= (nxt == ST_COOK && st != ST_COOK) ? '0 :
                        (st == ST_COOK && tick_100Hz) ?
                            ((duty_cnt == DW'(TICKS_PER_SEC - 1)) ? '0 : duty_cnt + DW'(1)) :
                        duty_cnt;
            magnetron_on <= (st == ST_COOK) && (duty_cnt < pwr_x10);
        end
    end

    mw_beeper #(
        .BEEP_HALF  (BEEP_HALF),
        .BEEP_COUNT (BEEP_COUNT)
    ) u_beeper (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .tick_100Hz (tick_100Hz),
        .start      (bp_start),
        .abort      (bp_abort),
        .beeper     (beeper),
        .done       (bp_done)
    );

endmodule

// File: tb/tb_microwave_ctrl.sv
// tb_microwave_ctrl: directed scenario bench for the microwave cook controller
module tb_microwave_ctrl;

    logic       clk_100MHz = 1'b0;
    logic       reset;
    logic       tick_100Hz;
    logic       btn_start;
    logic       btn_stop;
    logic       door_open;
    logic       time_zero;
    logic [3:0] power_lvl;
    logic       timer_run;
    logic       timer_clear;
    logic       magnetron_on;
    logic       lamp_on;
    logic       beeper;
    logic [1:0] state;
    logic [2:0] rgb;

    int vec  = 0;
    int errs = 0;

    microwave_ctrl dut (
        .clk_100MHz   (clk_100MHz),
        .reset        (reset),
        .tick_100Hz   (tick_100Hz),
        .btn_start    (btn_start),
        .btn_stop     (btn_stop),
        .door_open    (door_open),
        .time_zero    (time_zero),
        .power_lvl    (power_lvl),
        .timer_run    (timer_run),
        .timer_clear  (timer_clear),
        .magnetron_on (magnetron_on),
        .lamp_on      (lamp_on),
        .beeper       (beeper),
        .state        (state),
        .rgb          (rgb)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic step();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic tick1();
        tick_100Hz = 1'b1;
        step();
        tick_100Hz = 1'b0;
        step();
    endtask

    task automatic press_start();
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
    endtask

    task automatic press_stop();
        btn_stop = 1'b1;
        step();
        btn_stop = 1'b0;
    endtask

    task automatic test_reset();
        vec++; if (state !== 2'd0) begin errs++; $display("FAIL reset_state got %0d want 0", state); end
        vec++; if (rgb !== 3'b110) begin errs++; $display("FAIL reset_rgb got %b want 110", rgb); end
        vec++; if ({timer_run, timer_clear, magnetron_on, lamp_on, beeper} !== 5'b0) begin
            errs++; $display("FAIL reset_outs got %b want 00000", {timer_run, timer_clear, magnetron_on, lamp_on, beeper});
        end
        reset = 1'b0;
        step();
        vec++; if (state !== 2'd0 || timer_clear !== 1'b0) begin
            errs++; $display("FAIL reset_release got st=%0d clr=%b want st=0 clr=0", state, timer_clear);
        end
    endtask

    task automatic test_idle_guards();
        time_zero = 1'b1;
        press_start();
        vec++; if (state !== 2'd0) begin errs++; $display("FAIL idle_tz_start got %0d want 0", state); end
        time_zero = 1'b0;
        door_open = 1'b1;
        press_start();
        vec++; if (state !== 2'd0) begin errs++; $display("FAIL idle_door_start got %0d want 0", state); end
        vec++; if (lamp_on !== 1'b1) begin errs++; $display("FAIL idle_door_lamp got %b want 1", lamp_on); end
        door_open = 1'b0;
        press_stop();
        vec++; if (timer_clear !== 1'b1 || state !== 2'd0) begin
            errs++; $display("FAIL idle_stop_clr got clr=%b st=%0d want clr=1 st=0", timer_clear, state);
        end
        step();
        vec++; if (timer_clear !== 1'b0) begin errs++; $display("FAIL idle_clr_width got %b want 0", timer_clear); end
    endtask

    task automatic test_cook_duty();
        power_lvl = 4'd5;
        press_start();
        vec++; if (state !== 2'd1 || timer_run !== 1'b1 || rgb !== 3'b101) begin
            errs++; $display("FAIL cook_entry got st=%0d run=%b rgb=%b want st=1 run=1 rgb=101", state, timer_run, rgb);
        end
        step();
        vec++; if (magnetron_on !== 1'b1) begin errs++; $display("FAIL cook_mag0 got %b want 1", magnetron_on); end
        for (int k = 1; k <= 200; k++) begin
            tick1();
            vec++; if (magnetron_on !== ((k % 100) < 50)) begin
                errs++; $display("FAIL cook_duty tick=%0d got %b want %b", k, magnetron_on, (k % 100) < 50);
            end
        end
    endtask

    task automatic test_door_pause();
        door_open = 1'b1;
        step();
        vec++; if (state !== 2'd2 || lamp_on !== 1'b1 || timer_run !== 1'b0 || rgb !== 3'b110) begin
            errs++; $display("FAIL pause_door got st=%0d lamp=%b run=%b rgb=%b want 2 1 0 110", state, lamp_on, timer_run, rgb);
        end
        step();
        vec++; if (magnetron_on !== 1'b0) begin errs++; $display("FAIL pause_mag got %b want 0", magnetron_on); end
        press_start();
        vec++; if (state !== 2'd2) begin errs++; $display("FAIL pause_door_start got %0d want 2", state); end
        power_lvl = 4'd0;
        door_open = 1'b0;
        step();
        press_start();
        vec++; if (state !== 2'd1) begin errs++; $display("FAIL resume got %0d want 1", state); end
        step();
        vec++; if (magnetron_on !== 1'b1) begin errs++; $display("FAIL resume_mag got %b want 1", magnetron_on); end
        for (int k = 1; k <= 60; k++) begin
            tick1();
            vec++; if (magnetron_on !== (k < 50)) begin
                errs++; $display("FAIL resume_duty tick=%0d got %b want %b", k, magnetron_on, k < 50);
            end
        end
    endtask

    task automatic test_done();
        time_zero = 1'b1;
        step();
        vec++; if (state !== 2'd3 || rgb !== 3'b011 || beeper !== 1'b1 || timer_run !== 1'b0) begin
            errs++; $display("FAIL done_entry got st=%0d rgb=%b bp=%b run=%b want 3 011 1 0", state, rgb, beeper, timer_run);
        end
        for (int k = 1; k <= 300; k++) begin
            tick1();
            vec++; if (state !== ((k < 300) ? 2'd3 : 2'd0)) begin
                errs++; $display("FAIL done_state tick=%0d got %0d want %0d", k, state, (k < 300) ? 3 : 0);
            end
            vec++; if (beeper !== (k < 300 && ((k / 50) % 2) == 0)) begin
                errs++; $display("FAIL done_beep tick=%0d got %b want %b", k, beeper, k < 300 && ((k / 50) % 2) == 0);
            end
        end
        vec++; if (rgb !== 3'b110) begin errs++; $display("FAIL done_rgb got %b want 110", rgb); end
        press_start();
        vec++; if (state !== 2'd0) begin errs++; $display("FAIL idle_tz_after_done got %0d want 0", state); end
        time_zero = 1'b0;
    endtask

    task automatic test_done_abort();
        power_lvl = 4'd5;
        press_start();
        time_zero = 1'b1;
        step();
        vec++; if (state !== 2'd3 || beeper !== 1'b1) begin
            errs++; $display("FAIL abort_entry got st=%0d bp=%b want 3 1", state, beeper);
        end
        for (int k = 0; k < 10; k++) tick1();
        door_open = 1'b1;
        step();
        vec++; if (state !== 2'd0 || beeper !== 1'b0 || timer_clear !== 1'b0) begin
            errs++; $display("FAIL abort_door got st=%0d bp=%b clr=%b want 0 0 0", state, beeper, timer_clear);
        end
        door_open = 1'b0;
        time_zero = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        press_start();
        press_stop();
        vec++; if (state !== 2'd2 || timer_clear !== 1'b0) begin
            errs++; $display("FAIL cook_stop got st=%0d clr=%b want 2 0", state, timer_clear);
        end
        btn_start = 1'b1;
        btn_stop  = 1'b1;
        step();
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        vec++; if (state !== 2'd0 || timer_clear !== 1'b1 || timer_run !== 1'b0) begin
            errs++; $display("FAIL both_btn got st=%0d clr=%b run=%b want 0 1 0", state, timer_clear, timer_run);
        end
        step();
        vec++; if (timer_clear !== 1'b0) begin errs++; $display("FAIL both_clr_width got %b want 0", timer_clear); end
    endtask

    task automatic test_power_limits();
        power_lvl = 4'd15;
        press_start();
        step();
        for (int k = 1; k <= 150; k++) begin
            tick1();
            vec++; if (magnetron_on !== 1'b1) begin errs++; $display("FAIL pwr15 tick=%0d got %b want 1", k, magnetron_on); end
        end
        press_stop();
        press_stop();
        power_lvl = 4'd0;
        press_start();
        step();
        for (int k = 1; k <= 120; k++) begin
            tick1();
            vec++; if (magnetron_on !== 1'b0 || timer_run !== 1'b1) begin
                errs++; $display("FAIL pwr0 tick=%0d got mag=%b run=%b want 0 1", k, magnetron_on, timer_run);
            end
        end
        press_stop();
        press_stop();
    endtask

    task automatic test_reset_mid_cook();
        power_lvl = 4'd10;
        press_start();
        step();
        tick1();
        vec++; if (magnetron_on !== 1'b1 || state !== 2'd1) begin
            errs++; $display("FAIL pre_reset got mag=%b st=%0d want 1 1", magnetron_on, state);
        end
        @(negedge clk_100MHz);
        reset = 1'b1;
        #1;
        vec++; if (state !== 2'd0 || rgb !== 3'b110 ||
                   {timer_run, timer_clear, magnetron_on, lamp_on, beeper} !== 5'b0) begin
            errs++; $display("FAIL async_reset got st=%0d rgb=%b outs=%b want 0 110 00000", state, rgb,
                             {timer_run, timer_clear, magnetron_on, lamp_on, beeper});
        end
        step();
        reset = 1'b0;
        step();
        vec++; if (state !== 2'd0 || timer_clear !== 1'b0 || magnetron_on !== 1'b0) begin
            errs++; $display("FAIL post_reset got st=%0d clr=%b mag=%b want 0 0 0", state, timer_clear, magnetron_on);
        end
    endtask

    initial begin
        reset      = 1'b1;
        tick_100Hz = 1'b0;
        btn_start  = 1'b0;
        btn_stop   = 1'b0;
        door_open  = 1'b0;
        time_zero  = 1'b0;
        power_lvl  = 4'd5;
        step();
        step();
        test_reset();
        test_idle_guards();
        test_cook_duty();
        test_door_pause();
        test_done();
        test_done_abort();
        test_back_to_back();
        test_power_limits();
        test_reset_mid_cook();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
